// File: rtl/mfp_sys_lite.sv
// rtl/mfp_sys_lite.sv - reduced MIPSfpga system: fixed-sequence AHB-Lite master plus GPIO slave.
// Optional MFP_SYS_INPUT_SYNC_EN adds 2-flop synchronizers on switches, buttons and UART_RX.
module mfp_sys_lite #(
  parameter logic [31:0] BOOT_BASE = 32'h1FC0_0000,
  parameter logic [31:0] BOOT_LAST = 32'h1FC0_00CC,
  parameter logic [31:0] USER_BASE = 32'h0000_0260,
  parameter logic [31:0] USER_LAST = 32'h0000_03FC,
  parameter logic [31:0] GPIO_LED  = 32'h1F80_0000,
  parameter logic [31:0] GPIO_SW   = 32'h1F80_0004,
  parameter logic [31:0] GPIO_PB   = 32'h1F80_0008,
  parameter logic [31:0] GPIO_UART = 32'h1F80_000C,
  parameter int          N_SW      = 16,
  parameter int          N_LED     = 16
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset,
  input  logic              SI_ColdReset_N,
  input  logic              EJ_TRST_N_probe,
  input  logic              EJ_TDI,
  input  logic              EJ_TMS,
  input  logic              EJ_TCK,
  input  logic              EJ_DINT,
  output logic              EJ_TDO,
  input  logic [N_SW-1:0]   IO_Switch,
  input  logic [4:0]        IO_PB,
  input  logic              UART_RX,
  output logic [N_LED-1:0]  IO_LED,
  output logic [31:0]       HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA
);

  typedef enum logic [2:0] {ST_BOOT, ST_FETCH, ST_RD_SW, ST_WR_LED, ST_RD_PB} state_t;

  state_t            state_q, state_d;
  logic [31:0]       boot_addr_q, boot_addr_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       dp_addr_q;
  logic              dp_write_q;
  logic [31:0]       hwdata_q;
  logic [N_LED-1:0]  led_q;
  logic [N_SW-1:0]   sw_v;
  logic [4:0]        pb_v;
  logic              rx_v;
  logic              unused_pins;

  assign unused_pins = ^{SI_ColdReset_N, EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT};

`ifdef MFP_SYS_INPUT_SYNC_EN
  logic [N_SW-1:0] sw_s1_q, sw_s2_q;
  logic [4:0]      pb_s1_q, pb_s2_q;
  logic            rx_s1_q, rx_s2_q;

  // UART_RX idles high, so its synchronizer resets to 1.
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      pb_s1_q <= '0;
      pb_s2_q <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      sw_s1_q <= IO_Switch;
      sw_s2_q <= sw_s1_q;
      pb_s1_q <= IO_PB;
      pb_s2_q <= pb_s1_q;
      rx_s1_q <= UART_RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign sw_v = sw_s2_q;
  assign pb_v = pb_s2_q;
  assign rx_v = rx_s2_q;
`else
  assign sw_v = IO_Switch;
  assign pb_v = IO_PB;
  assign rx_v = UART_RX;
`endif

  always_comb begin
    state_d     = state_q;
    boot_addr_d = boot_addr_q;
    pc_d        = pc_q;
    HADDR       = boot_addr_q;
    HWRITE      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        HADDR = boot_addr_q;
        if (boot_addr_q == BOOT_LAST) begin
          state_d = ST_FETCH;
          pc_d    = USER_BASE;
        end else begin
          boot_addr_d = boot_addr_q + 32'd4;
        end
      end
      ST_FETCH: begin
        HADDR   = pc_q;
        state_d = ST_RD_SW;
      end
      ST_RD_SW: begin
        HADDR   = GPIO_SW;
        state_d = ST_WR_LED;
      end
      ST_WR_LED: begin
        HADDR   = GPIO_LED;
        HWRITE  = 1'b1;
        state_d = ST_RD_PB;
      end
      ST_RD_PB: begin
        HADDR   = GPIO_PB;
        state_d = ST_FETCH;
        pc_d    = (pc_q == USER_LAST) ? USER_BASE : pc_q + 32'd4;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Write data is captured at the end of the WR_LED address phase so it is valid
  // throughout the following data phase; the LED register takes it one cycle later.
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state_q     <= ST_BOOT;
      boot_addr_q <= BOOT_BASE;
      pc_q        <= USER_BASE;
      dp_addr_q   <= BOOT_BASE;
      dp_write_q  <= 1'b0;
      hwdata_q    <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_addr_q <= boot_addr_d;
      pc_q        <= pc_d;
      dp_addr_q   <= HADDR;
      dp_write_q  <= HWRITE;
      if (HWRITE) begin
        hwdata_q <= 32'(sw_v);
      end
      if (dp_write_q && dp_addr_q == GPIO_LED) begin
        led_q <= hwdata_q[N_LED-1:0];
      end
    end
  end

  always_comb begin
    HRDATA = 32'h0000_0000;
    if (!dp_write_q) begin
      case (dp_addr_q)
        GPIO_SW:   HRDATA = 32'(sw_v);
        GPIO_PB:   HRDATA = 32'(pb_v);
        GPIO_LED:  HRDATA = 32'(led_q);
        GPIO_UART: HRDATA = {31'b0, rx_v};
        default:   HRDATA = 32'h0000_0000;
      endcase
    end
  end

  assign HSIZE  = 3'b010;
  assign HWDATA = hwdata_q;
  assign IO_LED = led_q;
  assign EJ_TDO = 1'b0;

endmodule

// File: tb/tb_mfp_sys_lite.sv
// tb/tb_mfp_sys_lite.sv - randomized self-checking bench for mfp_sys_lite against a cycle-indexed model.
module tb_mfp_sys_lite;

  localparam logic [31:0] BOOT_BASE = 32'h1FC0_0000;
  localparam logic [31:0] USER_BASE = 32'h0000_0260;
  localparam logic [31:0] GPIO_LED  = 32'h1F80_0000;
  localparam logic [31:0] GPIO_SW   = 32'h1F80_0004;
  localparam logic [31:0] GPIO_PB   = 32'h1F80_0008;
  localparam logic [31:0] GPIO_UART = 32'h1F80_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  pb;
  logic        rx;
  logic        ej_tdo;
  logic [15:0] led;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite;
  logic [2:0]  hsize;

  always #5 clk = ~clk;

  mfp_sys_lite dut (
    .SI_ClkIn(clk), .SI_Reset(rst), .SI_ColdReset_N(1'b1),
    .EJ_TRST_N_probe(1'b1), .EJ_TDI(1'b0), .EJ_TMS(1'b0), .EJ_TCK(1'b0), .EJ_DINT(1'b0),
    .EJ_TDO(ej_tdo), .IO_Switch(sw), .IO_PB(pb), .UART_RX(rx), .IO_LED(led),
    .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata)
  );

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  bit valid = 0;
  bit first_pass = 1;

  logic [31:0] m_prev_addr;
  bit          m_prev_wr;
  logic [31:0] m_hwdata;
  logic [15:0] m_led;
  logic [15:0] h_sw1, h_sw2;
  logic [4:0]  h_pb1, h_pb2;
  logic        h_rx1, h_rx2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d after reset)", nm, act, exp, n);
    end
  endtask

  // Boot is 52 sequential fetches; afterwards a 4-step loop over 104 user words.
  function automatic logic [31:0] exp_addr(input int k);
    int m;
    if (k <= 51) return BOOT_BASE + 32'(4 * k);
    m = k - 52;
    case (m % 4)
      0:       return USER_BASE + 32'(4 * ((m / 4) % 104));
      1:       return GPIO_SW;
      2:       return GPIO_LED;
      default: return GPIO_PB;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [15:0] esw;
    logic [4:0]  epb;
    logic        erx;
    logic [31:0] ea, erd;
    bit          ew;
`ifdef MFP_SYS_INPUT_SYNC_EN
    esw = h_sw2; epb = h_pb2; erx = h_rx2;
`else
    esw = sw; epb = pb; erx = rx;
`endif
    ea = exp_addr(n);
    ew = (n > 51) && (((n - 52) % 4) == 2);
    if (valid) begin
      erd = 32'h0;
      if (!m_prev_wr) begin
        if (m_prev_addr == GPIO_SW)   erd = {16'b0, esw};
        if (m_prev_addr == GPIO_PB)   erd = {27'b0, epb};
        if (m_prev_addr == GPIO_LED)  erd = {16'b0, m_led};
        if (m_prev_addr == GPIO_UART) erd = {31'b0, erx};
      end
      chk("HADDR", haddr, ea);
      chk("HWRITE", {31'b0, hwrite}, {31'b0, ew});
      chk("HSIZE", {29'b0, hsize}, 32'd2);
      chk("HWDATA", hwdata, m_hwdata);
      chk("HRDATA", hrdata, erd);
      chk("IO_LED", {16'b0, led}, {16'b0, m_led});
      chk("EJ_TDO", {31'b0, ej_tdo}, 32'd0);
      if (n == 0) begin
        chk("rst_haddr", haddr, 32'h1FC0_0000);
        chk("rst_led", {16'b0, led}, 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
      end
      if (n == 51) chk("boot_last", haddr, 32'h1FC0_00CC);
      if (n == 52) chk("user_base", haddr, 32'h0000_0260);
      if (first_pass && n == 54) chk("rd_sw_data", hrdata, 32'h2B);
      if (first_pass && n == 55) chk("wr_led_data", hwdata, 32'h2B);
      if (first_pass && n == 56) chk("led_2cyc", {16'b0, led}, 32'h2B);
      if (first_pass && n == 56) chk("rd_pb_data", hrdata, 32'h15);
      if (n == 464) chk("pc_last", haddr, 32'h0000_03FC);
      if (n == 468) chk("pc_wrap", haddr, 32'h0000_0260);
    end
    if (rst) begin
      n = 0; m_prev_addr = BOOT_BASE; m_prev_wr = 0; m_hwdata = 0; m_led = 0;
      h_sw1 = 0; h_sw2 = 0; h_pb1 = 0; h_pb2 = 0; h_rx1 = 1; h_rx2 = 1;
      valid = 1;
    end else if (valid) begin
      if (m_prev_wr) m_led = m_hwdata[15:0];
      if (ew) m_hwdata = {16'b0, esw};
      m_prev_addr = ea;
      m_prev_wr = ew;
      n++;
      h_sw2 = h_sw1; h_sw1 = sw;
      h_pb2 = h_pb1; h_pb1 = pb;
      h_rx2 = h_rx1; h_rx1 = rx;
    end
  end

  task automatic step(input int cycles, input bit randomize_inputs);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (randomize_inputs) begin
        if ($urandom_range(0, 5) == 0) sw = 16'($urandom);
        if ($urandom_range(0, 5) == 0) pb = 5'($urandom);
        if ($urandom_range(0, 7) == 0) rx = 1'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sw = 16'h002B;
    pb = 5'h15;
    rx = 1'b1;
    step(10, 0);
    rst = 1'b0;
    step(70, 0);
    step(450, 1);
    sw = 16'hFFFF;
    step(10 + int'($urandom_range(0, 3)), 0);
    first_pass = 0;
    rst = 1'b1;
    step(1, 0);
    rst = 1'b0;
    step(80, 1);
    step(2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mfp_sys_lite.md
Name: mfp_sys_lite

Overview:
- Self-contained, reduced MIPSfpga system model for simulation bring-up and board smoke tests.
- An internal fixed-sequence AHB-Lite master replays the boot-ROM fetch stream, then loops a small "user program". The user program reads the switches, writes them to the LEDs and reads the push-buttons.
- A GPIO slave sits on the same AHB-Lite bus. The bus signals are exported so a bench can watch boot progress on HADDR.
- EJTAG pins are present for pin-compatibility only.

Parameters:
- BOOT_BASE, 32'h1FC0_0000, reset vector; first fetch address.
- BOOT_LAST, 32'h1FC0_00CC, last boot fetch address (data-cache-init point).
- USER_BASE, 32'h0000_0260, first user-code fetch address.
- USER_LAST, 32'h0000_03FC, last user fetch address before PC wraps.
- GPIO_LED, 32'h1F80_0000, LED register address (read/write).
- GPIO_SW, 32'h1F80_0004, switch register address (read-only).
- GPIO_PB, 32'h1F80_0008, push-button register address (read-only).
- GPIO_UART, 32'h1F80_000C, UART_RX status address (bit0, read-only).
- N_SW, 16, switch count.
- N_LED, 16, LED count.

Ports:
- SI_ClkIn  in  1  system clock; all logic on rising edge.
- SI_Reset  in  1  reset, synchronous, active-high.
- SI_ColdReset_N  in  1  reserved; ignored.
- EJ_TRST_N_probe, EJ_TDI, EJ_TMS, EJ_TCK, EJ_DINT  in  1 each  reserved; ignored.
- EJ_TDO  out  1  constant 0.
- IO_Switch  in  N_SW  slide switches.
- IO_PB  in  5  push-buttons.
- UART_RX  in  1  UART receive line; idle level is 1.
- IO_LED  out  N_LED  LED register.
- HADDR  out  32  AHB address phase.
- HWRITE  out  1  1 = write transfer.
- HSIZE  out  3  always 3'b010 (word).
- HWDATA  out  32  write data phase.
- HRDATA  out  32  read data phase (mux output).

Behaviour:
- Reset (SI_Reset=1 at a clock edge):
  - HADDR=BOOT_BASE, HWRITE=0, HWDATA=0, IO_LED=0.
  - Data-phase address register = BOOT_BASE, so HRDATA=0.
  - FSM enters BOOT.
- FSM states: BOOT, FETCH, RD_SW, WR_LED, RD_PB. One address phase per cycle; no wait states.
- BOOT:
  - HADDR advances +4 each cycle from BOOT_BASE.
  - When HADDR==BOOT_LAST, the next cycle goes to FETCH with PC=USER_BASE.
  - First non-reset cycle shows BOOT_BASE; BOOT_LAST appears 51 cycles later; USER_BASE 52 cycles later.
- FETCH: HADDR=PC, read → RD_SW.
- RD_SW: HADDR=GPIO_SW, read → WR_LED.
- WR_LED: HADDR=GPIO_LED, HWRITE=1 → RD_PB.
- RD_PB:
  - HADDR=GPIO_PB, read → FETCH.
  - PC=PC+4, wrapping from USER_LAST to USER_BASE.
- HWRITE is 1 only during WR_LED address phases.
- Data phase (the cycle after an address phase) uses a registered copy of the previous HADDR/HWRITE.
- HWDATA:
  - In the WR_LED data phase, HWDATA={zeros, switch value}.
  - Otherwise HWDATA holds its last value.
- IO_LED:
  - Loads HWDATA[N_LED-1:0] at the end of the WR_LED data phase.
  - The new value is visible 2 cycles after the WR_LED address phase.
- HRDATA, combinational from the data-phase address:
  - GPIO_SW → zero-extended switches.
  - GPIO_PB → zero-extended PB.
  - GPIO_LED → zero-extended IO_LED.
  - GPIO_UART → {31'b0, UART_RX}.
  - Any other address (boot or user memory) → 32'h0000_0000 (NOP).
  - Write data phases → 0.
- Reset asserted mid-sequence: the same edge restores all reset values; there are no partial LED writes after reset.
- Switch changes are seen at the next RD_SW/WR_LED pass; there is no loss or duplication.

Optional Feature:
- MFP_SYS_INPUT_SYNC_EN defined:
  - IO_Switch, IO_PB and UART_RX pass through 2-flop synchronizers (reset to 0, 0, 1).
  - All reads and the LED write data use the synchronized values; input-to-read latency is +2 cycles.
- Undefined: raw inputs are used directly.

Test Plan:
- Hold reset 10 cycles, release → HADDR=0x1FC00000 on the first free cycle, +4 per cycle, 0x1FC000CC after 51 cycles, then 0x00000260; HWRITE=0 and HSIZE=3'b010 throughout boot.
- IO_Switch=0x002B → first user loop: addresses 0x260, 0x1F800004, 0x1F800000 (HWRITE=1), 0x1F800008; HRDATA=0x2B in the RD_SW data phase; HWDATA=0x2B; IO_LED=0x002B two cycles after the write address.
- IO_PB=5'h15, UART_RX=1 → HRDATA=0x15 in the RD_PB data phase; a bench-forced GPIO_UART read returns 0x1.
- Run until PC=0x3FC → the next FETCH address is 0x260.
- Change IO_Switch to 0xFFFF mid-loop → IO_LED=0xFFFF after the following WR_LED; assert reset mid-loop → IO_LED=0 and HADDR=0x1FC00000 next cycle.
- With MFP_SYS_INPUT_SYNC_EN defined, a switch change 1 cycle before RD_SW → the old value is read; the new value is read on the next pass.
